// File: rtl/ls_issue_queue_gen.sv
// ls_issue_queue_gen: collapsing, age-ordered load/store issue queue with CDB wakeup and oldest-ready select.
// Define LSQ_CDB_BYPASS_EN to capture a same-cycle CDB broadcast into a dispatching entry.
module ls_issue_queue_gen #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5,
  parameter int DATA_W = 32,
  parameter int IMM_W = 16
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Dispatch_Enable,
  input  logic                         Dispatch_Opcode,
  input  logic [TAG_W-1:0]             Dispatch_Rd_Tag,
  input  logic [TAG_W-1:0]             Dispatch_Rs_Tag,
  input  logic [TAG_W-1:0]             Dispatch_Rt_Tag,
  input  logic [DATA_W-1:0]            Dispatch_Rs_Data,
  input  logic [DATA_W-1:0]            Dispatch_Rt_Data,
  input  logic                         Dispatch_Rs_Data_Val,
  input  logic                         Dispatch_Rt_Data_Val,
  input  logic [IMM_W-1:0]             Dispatch_Imm,
  output logic                         IssueQue_Full,
  output logic [$clog2(DEPTH+1)-1:0]   IssueQue_Count,
  input  logic                         CDB_Valid,
  input  logic [TAG_W-1:0]             CDB_Tag,
  input  logic [DATA_W-1:0]            CDB_Data,
  output logic                         IssueQue_Ready,
  output logic                         IssueQue_Opcode,
  output logic [DATA_W-1:0]            IssueQue_Address,
  output logic [DATA_W-1:0]            IssueQue_Data,
  output logic [TAG_W-1:0]             IssueQue_Rd_Tag,
  input  logic                         Issueblk_Issue,
  input  logic                         RB_Store_Ready,
  input  logic                         RB_Flush_Valid
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);
  logic [DEPTH-1:0] vld, op, rs_v, rt_v, rdy;
  logic [TAG_W-1:0] rd_t [DEPTH];
  logic [TAG_W-1:0] rs_t [DEPTH];
  logic [TAG_W-1:0] rt_t [DEPTH];
  logic [DATA_W-1:0] rt_d [DEPTH];
  logic [DATA_W-1:0] addr [DEPTH];
  logic [IMM_W-1:0] imm [DEPTH];
  logic [DEPTH-1:0] n_vld, n_op, n_rs_v, n_rt_v;
  logic [TAG_W-1:0] n_rd_t [DEPTH];
  logic [TAG_W-1:0] n_rs_t [DEPTH];
  logic [TAG_W-1:0] n_rt_t [DEPTH];
  logic [DATA_W-1:0] n_rt_d [DEPTH];
  logic [DATA_W-1:0] n_addr [DEPTH];
  logic [IMM_W-1:0] n_imm [DEPTH];
  logic [CW-1:0] cnt, wr_idx;
  logic [IW-1:0] sel;
  logic fire, accept, d_rs_v, d_rt_v;
  logic [DATA_W-1:0] d_rs_d, d_rt_d;

  function automatic logic [DATA_W-1:0] sext(input logic [IMM_W-1:0] x);
    return DATA_W'($signed(x));
  endfunction

  assign rdy = vld & rs_v & (op | (rt_v & {DEPTH{RB_Store_Ready}}));

  always_comb begin
    sel = '0;
    for (int i = DEPTH-1; i >= 0; i--) sel = rdy[i] ? IW'(i) : sel;
  end

  assign IssueQue_Ready   = |rdy;
  assign IssueQue_Opcode  = op[sel];
  assign IssueQue_Address = addr[sel];
  assign IssueQue_Data    = rt_d[sel];
  assign IssueQue_Rd_Tag  = rd_t[sel];
  assign IssueQue_Count   = cnt;
  assign IssueQue_Full    = cnt == CW'(DEPTH);
  assign fire   = Issueblk_Issue & IssueQue_Ready;
  assign accept = Dispatch_Enable & (~IssueQue_Full | fire);
  assign wr_idx = cnt - CW'(fire);

`ifdef LSQ_CDB_BYPASS_EN
  logic rs_byp, rt_byp;
  assign rs_byp = ~Dispatch_Rs_Data_Val & CDB_Valid & (CDB_Tag == Dispatch_Rs_Tag);
  assign rt_byp = ~Dispatch_Rt_Data_Val & CDB_Valid & (CDB_Tag == Dispatch_Rt_Tag);
  assign d_rs_v = Dispatch_Rs_Data_Val | rs_byp;
  assign d_rt_v = Dispatch_Rt_Data_Val | rt_byp;
  assign d_rs_d = rs_byp ? CDB_Data : Dispatch_Rs_Data;
  assign d_rt_d = rt_byp ? CDB_Data : Dispatch_Rt_Data;
`else
  assign d_rs_v = Dispatch_Rs_Data_Val;
  assign d_rt_v = Dispatch_Rt_Data_Val;
  assign d_rs_d = Dispatch_Rs_Data;
  assign d_rt_d = Dispatch_Rt_Data;
`endif

  // Each slot takes its own entry or, at/above the issued slot, its upper neighbour; wakeup follows the moved entry.
  for (genvar j = 0; j < DEPTH; j++) begin : g_slot
    localparam int N = (j + 1 < DEPTH) ? j + 1 : j;
    logic mv, wr, b_vld, b_rs_v, b_rt_v, rs_hit, rt_hit;
    logic [TAG_W-1:0] b_rs_t, b_rt_t;
    logic [IMM_W-1:0] b_imm;
    assign mv     = fire & (IW'(j) >= sel);
    assign wr     = accept & (wr_idx == CW'(j));
    assign b_vld  = mv ? (j + 1 < DEPTH) & vld[N] : vld[j];
    assign b_rs_v = mv ? rs_v[N] : rs_v[j];
    assign b_rt_v = mv ? rt_v[N] : rt_v[j];
    assign b_rs_t = mv ? rs_t[N] : rs_t[j];
    assign b_rt_t = mv ? rt_t[N] : rt_t[j];
    assign b_imm  = mv ? imm[N] : imm[j];
    assign rs_hit = CDB_Valid & b_vld & ~b_rs_v & (CDB_Tag == b_rs_t);
    assign rt_hit = CDB_Valid & b_vld & ~b_rt_v & (CDB_Tag == b_rt_t);
    assign n_vld[j]  = wr | b_vld;
    assign n_op[j]   = wr ? Dispatch_Opcode : (mv ? op[N] : op[j]);
    assign n_rd_t[j] = wr ? Dispatch_Rd_Tag : (mv ? rd_t[N] : rd_t[j]);
    assign n_rs_t[j] = wr ? Dispatch_Rs_Tag : b_rs_t;
    assign n_rt_t[j] = wr ? Dispatch_Rt_Tag : b_rt_t;
    assign n_imm[j]  = wr ? Dispatch_Imm : b_imm;
    assign n_rs_v[j] = wr ? d_rs_v : b_rs_v | rs_hit;
    assign n_rt_v[j] = wr ? d_rt_v : b_rt_v | rt_hit;
    assign n_rt_d[j] = wr ? d_rt_d : rt_hit ? CDB_Data : (mv ? rt_d[N] : rt_d[j]);
    assign n_addr[j] = wr ? d_rs_d + sext(Dispatch_Imm) :
                       rs_hit ? CDB_Data + sext(b_imm) : (mv ? addr[N] : addr[j]);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      vld  <= '0;
      op   <= '0;
      rs_v <= '0;
      rt_v <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_t[i] <= '0;
        rs_t[i] <= '0;
        rt_t[i] <= '0;
        rt_d[i] <= '0;
        addr[i] <= '0;
        imm[i]  <= '0;
      end
    end else begin
      vld  <= RB_Flush_Valid ? '0 : n_vld;
      cnt  <= RB_Flush_Valid ? '0 : cnt + CW'(accept) - CW'(fire);
      op   <= n_op;
      rs_v <= n_rs_v;
      rt_v <= n_rt_v;
      rd_t <= n_rd_t;
      rs_t <= n_rs_t;
      rt_t <= n_rt_t;
      rt_d <= n_rt_d;
      addr <= n_addr;
      imm  <= n_imm;
    end
  end
endmodule

// File: tb/tb_ls_issue_queue_gen.sv
// tb_ls_issue_queue_gen: directed + random bench for ls_issue_queue_gen against a queue-based model with an issue scoreboard.
module tb_ls_issue_queue_gen;
  localparam int DEPTH = 4, TAG_W = 5, DATA_W = 32, IMM_W = 16, CW = $clog2(DEPTH+1);
  logic Clk = 0, Rst = 0;
  logic de = 0, dop = 0, drs_v = 0, drt_v = 0, cv = 0, iss = 0, sr = 0, fl = 0;
  logic [TAG_W-1:0] drd = 0, drs_t = 0, drt_t = 0, ct = 0;
  logic [DATA_W-1:0] drs_d = 0, drt_d = 0, cd = 0;
  logic [IMM_W-1:0] dimm = 0;
  logic full, ready, q_op;
  logic [CW-1:0] count;
  logic [DATA_W-1:0] q_addr, q_data;
  logic [TAG_W-1:0] q_rd;

  always #5 Clk = ~Clk;

  ls_issue_queue_gen #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .IMM_W(IMM_W)) dut (
    .Clk(Clk), .Rst(Rst), .Dispatch_Enable(de), .Dispatch_Opcode(dop),
    .Dispatch_Rd_Tag(drd), .Dispatch_Rs_Tag(drs_t), .Dispatch_Rt_Tag(drt_t),
    .Dispatch_Rs_Data(drs_d), .Dispatch_Rt_Data(drt_d),
    .Dispatch_Rs_Data_Val(drs_v), .Dispatch_Rt_Data_Val(drt_v), .Dispatch_Imm(dimm),
    .IssueQue_Full(full), .IssueQue_Count(count), .CDB_Valid(cv), .CDB_Tag(ct), .CDB_Data(cd),
    .IssueQue_Ready(ready), .IssueQue_Opcode(q_op), .IssueQue_Address(q_addr),
    .IssueQue_Data(q_data), .IssueQue_Rd_Tag(q_rd), .Issueblk_Issue(iss),
    .RB_Store_Ready(sr), .RB_Flush_Valid(fl));

  typedef struct {
    logic op; logic [TAG_W-1:0] rd, rs_t, rt_t; logic rs_v, rt_v;
    logic [DATA_W-1:0] rs_d, rt_d; logic [IMM_W-1:0] imm;
  } ent_t;
  typedef struct { logic op; logic [DATA_W-1:0] addr, data; logic [TAG_W-1:0] rd; } out_t;
  typedef struct {
    logic de, op, rs_v, rt_v, cv, iss, sr, fl;
    logic [TAG_W-1:0] rd, rs_t, rt_t, ct;
    logic [DATA_W-1:0] rs_d, rt_d, cd; logic [IMM_W-1:0] imm;
  } stim_t;

  ent_t q[$];
  out_t sb[$];
  out_t mo;
  stim_t t;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ent_ready(input ent_t e, input bit s_rdy);
    return e.rs_v && (e.op || (e.rt_v && s_rdy));
  endfunction

  function automatic logic [DATA_W-1:0] ea(input ent_t e);
    return e.rs_d + {{(DATA_W-IMM_W){e.imm[IMM_W-1]}}, e.imm};
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.sr = 1;
    return s;
  endfunction

  function automatic stim_t disp(input bit op, input int rd, input int rs_t, input bit rs_v,
                                 input logic [DATA_W-1:0] rs_d, input int rt_t, input bit rt_v,
                                 input logic [DATA_W-1:0] rt_d, input logic [IMM_W-1:0] imm);
    stim_t s;
    s = idle();
    s.de = 1; s.op = op; s.rd = TAG_W'(rd); s.rs_t = TAG_W'(rs_t); s.rs_v = rs_v; s.rs_d = rs_d;
    s.rt_t = TAG_W'(rt_t); s.rt_v = rt_v; s.rt_d = rt_d; s.imm = imm;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.de = $urandom_range(0, 9) < 6; s.op = $urandom_range(0, 1) == 1;
    s.rd = TAG_W'($urandom); s.rs_t = TAG_W'($urandom_range(0, 7)); s.rt_t = TAG_W'($urandom_range(0, 7));
    s.rs_v = $urandom_range(0, 1) == 1; s.rt_v = $urandom_range(0, 1) == 1;
    s.rs_d = $urandom; s.rt_d = $urandom; s.imm = IMM_W'($urandom);
    s.cv = $urandom_range(0, 1) == 1; s.ct = TAG_W'($urandom_range(0, 7)); s.cd = $urandom;
    s.iss = $urandom_range(0, 1) == 1; s.sr = $urandom_range(0, 3) != 0; s.fl = $urandom_range(0, 49) == 0;
    return s;
  endfunction

  // One clock cycle: drive, check the registered state against the model, then advance the model.
  task automatic step(input stim_t s);
    int sel, n0;
    bit fire;
    ent_t e;
    @(posedge Clk);
    #1;
    de = s.de; dop = s.op; drd = s.rd; drs_t = s.rs_t; drt_t = s.rt_t; drs_v = s.rs_v; drt_v = s.rt_v;
    drs_d = s.rs_d; drt_d = s.rt_d; dimm = s.imm; cv = s.cv; ct = s.ct; cd = s.cd;
    iss = s.iss; sr = s.sr; fl = s.fl;
    #1;
    sel = -1;
    for (int i = q.size() - 1; i >= 0; i--) if (ent_ready(q[i], s.sr)) sel = i;
    n0 = q.size();
    chk("ready", ready, sel >= 0);
    chk("count", count, n0);
    chk("full", full, n0 == DEPTH);
    if (sel < 0 && n0 > 0) chk("head_rd", q_rd, q[0].rd);
    fire = s.iss && sel >= 0;
    if (fire) sb.push_back('{q[sel].op, ea(q[sel]), q[sel].rt_d, q[sel].rd});
    if (s.fl) q.delete();
    else begin
      if (fire) q.delete(sel);
      foreach (q[i]) begin
        if (s.cv && !q[i].rs_v && q[i].rs_t == s.ct) begin q[i].rs_v = 1; q[i].rs_d = s.cd; end
        if (s.cv && !q[i].rt_v && q[i].rt_t == s.ct) begin q[i].rt_v = 1; q[i].rt_d = s.cd; end
      end
      if (s.de && (n0 < DEPTH || fire)) begin
        e = '{s.op, s.rd, s.rs_t, s.rt_t, s.rs_v, s.rt_v, s.rs_d, s.rt_d, s.imm};
`ifdef LSQ_CDB_BYPASS_EN
        if (!e.rs_v && s.cv && s.ct == e.rs_t) begin e.rs_v = 1; e.rs_d = s.cd; end
        if (!e.rt_v && s.cv && s.ct == e.rt_t) begin e.rt_v = 1; e.rt_d = s.cd; end
`endif
        q.push_back(e);
      end
    end
  endtask

  always @(negedge Clk) begin
    if (!Rst && iss && ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue_unexpected: got issue rd %0h expected none at %0t", q_rd, $time);
      end else begin
        mo = sb.pop_front();
        chk("iss_op", q_op, mo.op);
        chk("iss_addr", q_addr, mo.addr);
        chk("iss_data", q_data, mo.data);
        chk("iss_rd", q_rd, mo.rd);
      end
    end
  end

  initial begin
    #1 Rst = 1;
    #3;
    chk("rst_ready", ready, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_addr", q_addr, 0);
    chk("rst_data", q_data, 0);
    chk("rst_rd", q_rd, 0);
    chk("rst_op", q_op, 0);
    #8 Rst = 0;
    // single ready load
    step(disp(1, 3, 1, 1, 32'h100, 0, 0, 0, 16'hFFFC));
    step(idle());
    chk("t1_ready", ready, 1); chk("t1_addr", q_addr, 32'h0FC);
    chk("t1_rd", q_rd, 3); chk("t1_op", q_op, 1); chk("t1_count", count, 1);
    t = idle(); t.iss = 1; step(t);
    // store waiting on Rt
    step(disp(0, 4, 1, 1, 32'h200, 7, 0, 0, 16'h4));
    step(idle());
    chk("t2_notready", ready, 0);
    t = idle(); t.cv = 1; t.ct = 7; t.cd = 32'hDEAD; step(t);
    step(idle());
    chk("t2_ready", ready, 1); chk("t2_data", q_data, 32'hDEAD); chk("t2_addr", q_addr, 32'h204);
    t = idle(); t.iss = 1; step(t);
    // fill, drop, wake middle, collapse
    for (int i = 0; i < 4; i++) step(disp(1, 20 + i, 10 + i, 0, 0, 0, 0, 0, 16'h10));
    step(idle());
    chk("t3_full", full, 1); chk("t3_count", count, 4);
    step(disp(1, 24, 14, 0, 0, 0, 0, 0, 0));
    step(idle());
    chk("t3_drop_count", count, 4);
    t = idle(); t.cv = 1; t.ct = 12; t.cd = 32'h1000; step(t);
    step(idle());
    chk("t3_wake_rd", q_rd, 22); chk("t3_wake_addr", q_addr, 32'h1010);
    t = idle(); t.iss = 1; step(t);
    step(idle());
    chk("t3_count3", count, 3); chk("t3_notfull", full, 0);
    t = idle(); t.cv = 1; t.ct = 13; t.cd = 32'h2000; step(t);
    step(idle());
    chk("t3_shift_rd", q_rd, 23);
    // full queue: issue and dispatch together
    step(disp(1, 25, 15, 0, 0, 0, 0, 0, 0));
    t = disp(1, 26, 0, 1, 32'h10, 0, 0, 0, 0); t.iss = 1; step(t);
    step(idle());
    chk("t4_count", count, 4); chk("t4_rd", q_rd, 26);
    t = idle(); t.fl = 1; step(t);
    // store at head blocked by RB_Store_Ready
    step(disp(0, 5, 0, 1, 32'h300, 0, 1, 32'h55, 0));
    step(disp(1, 6, 0, 1, 32'h400, 0, 0, 0, 0));
    t = idle(); t.sr = 0; step(t);
    chk("t5_load_first", q_rd, 6);
    step(idle());
    chk("t5_store_head", q_rd, 5);
    // flush overrides dispatch
    step(disp(1, 8, 2, 0, 0, 0, 0, 0, 0));
    t = disp(1, 9, 0, 1, 0, 0, 0, 0, 0); t.fl = 1; step(t);
    step(idle());
    chk("t6_count", count, 0); chk("t6_ready", ready, 0);
    // same-cycle CDB during dispatch
    t = disp(1, 7, 9, 0, 0, 0, 0, 0, 16'h8); t.cv = 1; t.ct = 9; t.cd = 32'h40; step(t);
    step(idle());
`ifdef LSQ_CDB_BYPASS_EN
    chk("byp_ready", ready, 1); chk("byp_addr", q_addr, 32'h48);
`else
    chk("nobyp_ready", ready, 0);
`endif
    // asynchronous reset mid-run
    step(disp(1, 11, 0, 1, 32'h10, 0, 0, 0, 0));
    step(idle());
    #2 Rst = 1;
    #1;
    chk("arst_count", count, 0); chk("arst_ready", ready, 0); chk("arst_full", full, 0);
    q.delete();
    sb.delete();
    #1 Rst = 0;
    for (int i = 0; i < 3000; i++) step(rnd());
    step(idle());
    step(idle());
    chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
